// File: rtl/exe_alu_status.sv
// exe_alu_status: execute-stage ALU with NZCV status register and registered EXE/MEM output
module exe_alu_status #(
  parameter int REGISTER_LEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [3:0]              exe_cmd,
  input  logic [REGISTER_LEN-1:0] val1,
  input  logic [REGISTER_LEN-1:0] val2,
  input  logic                    s_bit,
  input  logic                    freeze,
  input  logic                    flush,
  output logic [REGISTER_LEN-1:0] alu_result,
  output logic                    out_valid,
  output logic [3:0]              status
);
  localparam int MSB = REGISTER_LEN - 1;
  logic [REGISTER_LEN-1:0] alu_result_q, alu_result_d, res, op_b;
  logic [REGISTER_LEN:0]   sum;
  logic [3:0]              status_q, status_d;
  logic                    out_valid_q, out_valid_d;
  logic                    is_arith, is_sub, known, cin, c_q, v_add, v_sub, we;
  // Operand conditioning, shared adder, result mux and flag generation
  always_comb begin
    c_q      = status_q[1];
    is_sub   = (exe_cmd == 4'b0100) || (exe_cmd == 4'b0101);
    is_arith = (exe_cmd >= 4'b0010) && (exe_cmd <= 4'b0101);
    known    = (exe_cmd >= 4'b0001) && (exe_cmd <= 4'b1001);
    op_b     = is_sub ? ~val2 : val2;
    cin      = (exe_cmd == 4'b0100) ? 1'b1 :
               ((exe_cmd == 4'b0011) || (exe_cmd == 4'b0101)) ? c_q : 1'b0;
    sum      = {1'b0, val1} + {1'b0, op_b} + (REGISTER_LEN+1)'(cin);
    res      = (exe_cmd == 4'b0001) ? val2 :
               (exe_cmd == 4'b1001) ? ~val2 :
               is_arith             ? sum[MSB:0] :
               (exe_cmd == 4'b0110) ? (val1 & val2) :
               (exe_cmd == 4'b0111) ? (val1 | val2) :
               (exe_cmd == 4'b1000) ? (val1 ^ val2) : '0;
    v_add    = (val1[MSB] == val2[MSB]) && (sum[MSB] != val1[MSB]);
    v_sub    = (val1[MSB] != val2[MSB]) && (sum[MSB] != val1[MSB]);
    we       = in_valid & s_bit & ~freeze & ~flush & known;
    status_d = we ? {res[MSB], res == '0,
                     is_arith ? sum[REGISTER_LEN] : c_q,
                     is_arith ? (is_sub ? v_sub : v_add) : status_q[0]} : status_q;
    alu_result_d = freeze ? alu_result_q : res;
    out_valid_d  = flush ? 1'b0 : freeze ? out_valid_q : in_valid;
  end
  // EXE/MEM pipeline register and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_q <= '0;
      out_valid_q  <= 1'b0;
      status_q     <= 4'b0000;
    end else begin
      alu_result_q <= alu_result_d;
      out_valid_q  <= out_valid_d;
      status_q     <= status_d;
    end
  end
  assign alu_result = alu_result_q;
  assign out_valid  = out_valid_q;
  assign status     = status_q;
endmodule

// File: tb/tb_exe_alu_status.sv
// tb_exe_alu_status: directed self-checking bench for exe_alu_status
module tb_exe_alu_status;
  logic        clk = 1'b0;
  logic        rst, in_valid, s_bit, freeze, flush;
  logic [3:0]  exe_cmd;
  logic [31:0] val1, val2, alu_result;
  logic        out_valid;
  logic [3:0]  status;
  int tests = 0;
  int fails = 0;

  exe_alu_status #(.REGISTER_LEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .exe_cmd(exe_cmd),
    .val1(val1), .val2(val2), .s_bit(s_bit), .freeze(freeze), .flush(flush),
    .alu_result(alu_result), .out_valid(out_valid), .status(status)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic fz, input logic fl);
    in_valid = v; exe_cmd = c; val1 = a; val2 = b; s_bit = s; freeze = fz; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b1; exe_cmd = 4'b0010; s_bit = 1'b1; freeze = 1'b0; flush = 1'b0;
    val1 = $urandom; val2 = $urandom;
    #2;
    tests++;
    if ({out_valid, status, alu_result} !== 37'd0) begin
      fails++; $display("FAIL reset_async: got v=%b nzcv=%b res=%h want all zero", out_valid, status, alu_result);
    end
    @(posedge clk); #1;
    tests++;
    if ({out_valid, status, alu_result} !== 37'd0) begin
      fails++; $display("FAIL reset_held: got v=%b nzcv=%b res=%h want all zero", out_valid, status, alu_result);
    end
    in_valid = 1'b0; s_bit = 1'b0; exe_cmd = 4'b0000;
    rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, status, alu_result} !== 37'd0) begin
      fails++; $display("FAIL reset_release: got v=%b nzcv=%b res=%h want all zero", out_valid, status, alu_result);
    end
    step(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_add_adc;
    step(1'b1, 4'b0010, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1001, 32'h80000000}) begin
      fails++; $display("FAIL add_ovf: got v=%b nzcv=%b res=%h want v=1 nzcv=1001 res=80000000", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0011, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b0100, 32'h0}) begin
      fails++; $display("FAIL adc_c0: got v=%b nzcv=%b res=%h want v=1 nzcv=0100 res=00000000", out_valid, status, alu_result);
    end
  endtask

  task automatic test_sub_sbc;
    step(1'b1, 4'b0100, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b0110, 32'h0}) begin
      fails++; $display("FAIL cmp_eq: got v=%b nzcv=%b res=%h want v=1 nzcv=0110 res=00000000", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0101, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b0010, 32'd7}) begin
      fails++; $display("FAIL sbc_c1: got v=%b nzcv=%b res=%h want v=1 nzcv=0010 res=00000007", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0100, 32'd3, 32'd10, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1000, 32'hFFFFFFF9}) begin
      fails++; $display("FAIL sub_neg: got v=%b nzcv=%b res=%h want v=1 nzcv=1000 res=fffffff9", out_valid, status, alu_result);
    end
  endtask

  task automatic test_logic_keeps_cv;
    step(1'b1, 4'b0010, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b0111, 32'h0}) begin
      fails++; $display("FAIL add_cv: got v=%b nzcv=%b res=%h want v=1 nzcv=0111 res=00000000", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0110, 32'hF0, 32'h0F, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b0111, 32'h0}) begin
      fails++; $display("FAIL and_tst: got v=%b nzcv=%b res=%h want v=1 nzcv=0111 res=00000000", out_valid, status, alu_result);
    end
    step(1'b1, 4'b1000, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1011, 32'h80000000}) begin
      fails++; $display("FAIL eor_neg: got v=%b nzcv=%b res=%h want v=1 nzcv=1011 res=80000000", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0111, 32'h00FF0000, 32'h000000FF, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1011, 32'h00FF00FF}) begin
      fails++; $display("FAIL orr_nos: got v=%b nzcv=%b res=%h want v=1 nzcv=1011 res=00ff00ff", out_valid, status, alu_result);
    end
  endtask

  task automatic test_freeze_flush;
    step(1'b1, 4'b1000, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0010, 32'd100 + 32'(i), 32'd7, 1'b1, 1'b1, 1'b0);
      tests++;
      if ({out_valid, status, alu_result} !== {1'b1, 4'b1011, 32'h80000000}) begin
        fails++; $display("FAIL freeze_%0d: got v=%b nzcv=%b res=%h want v=1 nzcv=1011 res=80000000", i, out_valid, status, alu_result);
      end
    end
    step(1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1);
    tests++;
    if ({out_valid, status} !== {1'b0, 4'b1011}) begin
      fails++; $display("FAIL flush: got v=%b nzcv=%b want v=0 nzcv=1011", out_valid, status);
    end
    step(1'b1, 4'b0010, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1011, 32'd5}) begin
      fails++; $display("FAIL add_nos: got v=%b nzcv=%b res=%h want v=1 nzcv=1011 res=00000005", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0010, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    tests++;
    if ({out_valid, status} !== {1'b0, 4'b1011}) begin
      fails++; $display("FAIL freeze_flush: got v=%b nzcv=%b want v=0 nzcv=1011", out_valid, status);
    end
  endtask

  task automatic test_mov_mvn_undef;
    step(1'b1, 4'b0001, 32'hDEAD, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b0111, 32'h0}) begin
      fails++; $display("FAIL mov_zero: got v=%b nzcv=%b res=%h want v=1 nzcv=0111 res=00000000", out_valid, status, alu_result);
    end
    step(1'b1, 4'b1001, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1011, 32'hFFFFFFFF}) begin
      fails++; $display("FAIL mvn: got v=%b nzcv=%b res=%h want v=1 nzcv=1011 res=ffffffff", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1011, 32'h0}) begin
      fails++; $display("FAIL mov_nos: got v=%b nzcv=%b res=%h want v=1 nzcv=1011 res=00000000", out_valid, status, alu_result);
    end
    step(1'b1, 4'b1111, 32'h0, 32'h5, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1011, 32'h0}) begin
      fails++; $display("FAIL undef_v1: got v=%b nzcv=%b res=%h want v=1 nzcv=1011 res=00000000", out_valid, status, alu_result);
    end
    step(1'b0, 4'b1111, 32'h1, 32'h5, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b0, 4'b1011, 32'h0}) begin
      fails++; $display("FAIL undef_v0: got v=%b nzcv=%b res=%h want v=0 nzcv=1011 res=00000000", out_valid, status, alu_result);
    end
    step(1'b0, 4'b0010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b0, 4'b1011, 32'h0}) begin
      fails++; $display("FAIL invalid_s: got v=%b nzcv=%b res=%h want v=0 nzcv=1011 res=00000000", out_valid, status, alu_result);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 4'b0100, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b1000, 32'hFFFFFFFF}) begin
      fails++; $display("FAIL b2b_sub: got v=%b nzcv=%b res=%h want v=1 nzcv=1000 res=ffffffff", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0011, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b0110, 32'h0}) begin
      fails++; $display("FAIL b2b_adc: got v=%b nzcv=%b res=%h want v=1 nzcv=0110 res=00000000", out_valid, status, alu_result);
    end
    step(1'b1, 4'b0011, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, status, alu_result} !== {1'b1, 4'b0000, 32'd3}) begin
      fails++; $display("FAIL b2b_adc_c1: got v=%b nzcv=%b res=%h want v=1 nzcv=0000 res=00000003", out_valid, status, alu_result);
    end
  endtask

  task automatic test_mid_reset;
    step(1'b1, 4'b0010, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({out_valid, status, alu_result} !== 37'd0) begin
      fails++; $display("FAIL mid_reset: got v=%b nzcv=%b res=%h want all zero", out_valid, status, alu_result);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_sub_sbc();
    test_logic_keeps_cv();
    test_freeze_flush();
    test_mov_mvn_undef();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
